// File: rtl/disparo_mapa.sv
// disparo_mapa: battleship shot handler tracking fired cells, hits, counters and game end
module disparo_mapa #(
  parameter int MAX_TIROS = 20
) (
  input  logic        clk_div,
  input  logic        reset,
  input  logic        ativo,
  input  logic        botao,
  input  logic [2:0]  linha,
  input  logic [2:0]  coluna,
  input  logic [34:0] pos,
  output logic [34:0] mapa_tiros,
  output logic [34:0] mapa_acertos,
  output logic [5:0]  tiros,
  output logic [5:0]  acertos,
  output logic        acerto,
  output logic        agua,
  output logic        repetido,
  output logic        invalido,
  output logic        fim_jogo,
  output logic        vitoria
);
  typedef enum logic [1:0] {ESPERA, JOGANDO, VERIFICA, FIM} state_t;
  state_t state, state_n;
  logic b_q, pend, win, fire, inv, rep, novo, hit;
  logic [2:0] lin_q, col_q;
  logic [5:0] idx, total, total_n, tiros_n, acertos_n;
  // shot classification for the latched coordinate
  always_comb begin
    fire      = botao && !b_q;
    idx       = {3'b000, lin_q} * 6'd5 + {3'b000, col_q};
    inv       = lin_q > 3'd6 || col_q > 3'd4;
    rep       = !inv && mapa_tiros[idx];
    novo      = !inv && !rep;
    hit       = novo && pos[idx];
    tiros_n   = tiros + 6'(novo);
    acertos_n = acertos + 6'(hit);
    total_n   = 6'($countones(pos));
  end
  // state register
  always_ff @(posedge clk_div)
    state <= reset ? ESPERA : state_n;
  // next-state logic; dropping ativo always wins over the shot result, and a win beats running out of shots
  always_comb begin
    state_n = state;
    unique case (state)
      ESPERA:   state_n = !ativo ? ESPERA : (total_n == 6'd0) ? FIM : JOGANDO;
      JOGANDO:  state_n = !ativo ? ESPERA : pend ? VERIFICA : JOGANDO;
      VERIFICA: state_n = !ativo ? ESPERA : (acertos_n == total || tiros_n == 6'(MAX_TIROS)) ? FIM : JOGANDO;
      FIM:      state_n = ativo ? FIM : ESPERA;
    endcase
  end
  // game-over outputs derived from state
  always_comb begin
    fim_jogo = state == FIM;
    vitoria  = fim_jogo && win;
  end
  // button edge register runs in every state
  always_ff @(posedge clk_div)
    b_q <= reset ? 1'b0 : botao;
  // datapath: a fire event is latched one edge before VERIFICA so results land two edges after the press
  always_ff @(posedge clk_div) begin
    if (reset || !ativo) begin
      {acerto, agua, repetido, invalido} <= 4'b0000;
      mapa_tiros   <= '0;
      mapa_acertos <= '0;
      tiros        <= '0;
      acertos      <= '0;
      total        <= '0;
      win          <= 1'b0;
      pend         <= 1'b0;
      lin_q        <= '0;
      col_q        <= '0;
    end else begin
      {acerto, agua, repetido, invalido} <= 4'b0000;
      pend <= state == JOGANDO && fire;
      if (state == JOGANDO && fire) begin
        lin_q <= linha;
        col_q <= coluna;
      end
      if (state == ESPERA) begin
        total <= total_n;
        win   <= total_n == 6'd0;
      end
      if (state == VERIFICA) begin
        {acerto, agua, repetido, invalido} <= {hit, novo && !hit, rep, inv};
        mapa_tiros   <= mapa_tiros | (35'(novo) << idx);
        mapa_acertos <= mapa_acertos | (35'(hit) << idx);
        tiros        <= tiros_n;
        acertos      <= acertos_n;
        win          <= acertos_n == total;
      end
    end
  end
endmodule

// File: tb/tb_disparo_mapa.sv
// tb_disparo_mapa: table-driven directed checks plus multi-cycle corner sequences
module tb_disparo_mapa;
  logic clk_div = 1'b0, reset = 1'b0, ativo = 1'b0, botao = 1'b0;
  logic [2:0] linha = '0, coluna = '0;
  logic [34:0] pos = '0;
  logic [34:0] mapa_tiros, mapa_acertos, t3_mt, t3_ma;
  logic [5:0] tiros, acertos, t3_tiros, t3_acertos;
  logic acerto, agua, repetido, invalido, fim_jogo, vitoria;
  logic t3_acerto, t3_agua, t3_repetido, t3_invalido, t3_fim, t3_vit;
  int n = 0, nf = 0;

  always #5 clk_div = ~clk_div;

  disparo_mapa dut (
    .clk_div(clk_div), .reset(reset), .ativo(ativo), .botao(botao), .linha(linha), .coluna(coluna), .pos(pos),
    .mapa_tiros(mapa_tiros), .mapa_acertos(mapa_acertos), .tiros(tiros), .acertos(acertos),
    .acerto(acerto), .agua(agua), .repetido(repetido), .invalido(invalido), .fim_jogo(fim_jogo), .vitoria(vitoria)
  );

  disparo_mapa #(.MAX_TIROS(3)) dut3 (
    .clk_div(clk_div), .reset(reset), .ativo(ativo), .botao(botao), .linha(linha), .coluna(coluna), .pos(pos),
    .mapa_tiros(t3_mt), .mapa_acertos(t3_ma), .tiros(t3_tiros), .acertos(t3_acertos),
    .acerto(t3_acerto), .agua(t3_agua), .repetido(t3_repetido), .invalido(t3_invalido), .fim_jogo(t3_fim), .vitoria(t3_vit)
  );

  typedef struct {
    bit          nova;
    logic [34:0] p;
    logic [2:0]  l, c;
    logic [3:0]  pul;
    logic [5:0]  t, a;
    logic        f, v;
    logic [34:0] mt, ma;
  } vec_t;
  vec_t vt [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start(input logic [34:0] p);
    @(negedge clk_div);
    reset = 1'b1;
    ativo = 1'b0;
    botao = 1'b0;
    @(negedge clk_div);
    reset = 1'b0;
    ativo = 1'b1;
    pos = p;
    @(negedge clk_div);
  endtask

  task automatic shot(input logic [2:0] l, input logic [2:0] c);
    linha = l;
    coluna = c;
    botao = 1'b1;
    @(negedge clk_div);
    botao = 1'b0;
    @(negedge clk_div);
    chk("early_pulse", 64'({acerto, agua, repetido, invalido}), 64'd0);
    @(negedge clk_div);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    vt[0]  = '{1'b1, 35'h7, 3'd0, 3'd0, 4'b1000, 6'd1, 6'd1, 1'b0, 1'b0, 35'h1, 35'h1};
    vt[1]  = '{1'b1, 35'h7, 3'd0, 3'd3, 4'b0100, 6'd1, 6'd0, 1'b0, 1'b0, 35'h8, 35'h0};
    vt[2]  = '{1'b0, 35'h7, 3'd0, 3'd3, 4'b0010, 6'd1, 6'd0, 1'b0, 1'b0, 35'h8, 35'h0};
    vt[3]  = '{1'b1, 35'h7, 3'd0, 3'd5, 4'b0001, 6'd0, 6'd0, 1'b0, 1'b0, 35'h0, 35'h0};
    vt[4]  = '{1'b0, 35'h7, 3'd7, 3'd0, 4'b0001, 6'd0, 6'd0, 1'b0, 1'b0, 35'h0, 35'h0};
    vt[5]  = '{1'b1, 35'h400000001, 3'd0, 3'd0, 4'b1000, 6'd1, 6'd1, 1'b0, 1'b0, 35'h1, 35'h1};
    vt[6]  = '{1'b0, 35'h400000001, 3'd6, 3'd4, 4'b1000, 6'd2, 6'd2, 1'b1, 1'b1, 35'h400000001, 35'h400000001};
    vt[7]  = '{1'b1, 35'h7, 3'd1, 3'd0, 4'b0100, 6'd1, 6'd0, 1'b0, 1'b0, 35'h20, 35'h0};
    vt[8]  = '{1'b0, 35'h7, 3'd0, 3'd1, 4'b1000, 6'd2, 6'd1, 1'b0, 1'b0, 35'h22, 35'h2};
    vt[9]  = '{1'b0, 35'h7, 3'd0, 3'd2, 4'b1000, 6'd3, 6'd2, 1'b0, 1'b0, 35'h26, 35'h6};
    vt[10] = '{1'b0, 35'h7, 3'd0, 3'd0, 4'b1000, 6'd4, 6'd3, 1'b1, 1'b1, 35'h27, 35'h7};

    @(negedge clk_div);
    reset = 1'b1;
    @(negedge clk_div);
    chk("reset_state", 64'({mapa_tiros, tiros, acertos, acerto, agua, repetido, invalido, fim_jogo, vitoria}), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      if (vt[i].nova) start(vt[i].p);
      shot(vt[i].l, vt[i].c);
      chk($sformatf("v%0d_pulses", i), 64'({acerto, agua, repetido, invalido}), 64'(vt[i].pul));
      chk($sformatf("v%0d_tiros", i), 64'(tiros), 64'(vt[i].t));
      chk($sformatf("v%0d_acertos", i), 64'(acertos), 64'(vt[i].a));
      chk($sformatf("v%0d_fim", i), 64'(fim_jogo), 64'(vt[i].f));
      chk($sformatf("v%0d_vitoria", i), 64'(vitoria), 64'(vt[i].v));
      chk($sformatf("v%0d_mapa_tiros", i), 64'(mapa_tiros), 64'(vt[i].mt));
      chk($sformatf("v%0d_mapa_acertos", i), 64'(mapa_acertos), 64'(vt[i].ma));
    end

    start(35'h7);
    linha = 3'd0;
    coluna = 3'd3;
    botao = 1'b1;
    cnt = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk_div);
      cnt += int'(acerto) + int'(agua) + int'(repetido) + int'(invalido);
      if (k == 9) botao = 1'b0;
    end
    chk("held_pulse_count", 64'(cnt), 64'd1);
    chk("held_tiros", 64'(tiros), 64'd1);

    start(35'h7);
    shot(3'd1, 3'd0);
    shot(3'd1, 3'd1);
    shot(3'd1, 3'd2);
    chk("loss_pulse", 64'({t3_acerto, t3_agua, t3_repetido, t3_invalido}), 64'b0100);
    chk("loss_fim_vit", 64'({t3_fim, t3_vit}), 64'b10);
    chk("loss_tiros", 64'(t3_tiros), 64'd3);
    linha = 3'd1;
    coluna = 3'd3;
    botao = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_div);
      botao = 1'b0;
      cnt += int'(t3_acerto) + int'(t3_agua) + int'(t3_repetido) + int'(t3_invalido);
    end
    chk("fim_ignores_fire", 64'(cnt), 64'd0);
    chk("fim_holds_tiros", 64'({t3_fim, t3_tiros}), 64'({1'b1, 6'd3}));

    start(35'h7);
    shot(3'd0, 3'd0);
    shot(3'd0, 3'd1);
    shot(3'd0, 3'd2);
    chk("win_priority_fim_vit", 64'({t3_fim, t3_vit}), 64'b11);
    chk("win_priority_counts", 64'({t3_tiros, t3_acertos}), 64'({6'd3, 6'd3}));

    start(35'h7);
    linha = 3'd0;
    coluna = 3'd0;
    botao = 1'b1;
    @(negedge clk_div);
    botao = 1'b0;
    @(negedge clk_div);
    reset = 1'b1;
    @(negedge clk_div);
    chk("reset_in_verifica", 64'({mapa_tiros, tiros, acertos, acerto, agua, repetido, invalido, fim_jogo, vitoria}), 64'd0);
    reset = 1'b0;

    start(35'h1);
    shot(3'd0, 3'd0);
    chk("single_ship_win", 64'({fim_jogo, vitoria}), 64'b11);
    ativo = 1'b0;
    @(negedge clk_div);
    chk("ativo_drop_clear", 64'({mapa_acertos, tiros, acertos, fim_jogo, vitoria}), 64'd0);
    chk("ativo_drop_mapa", 64'(mapa_tiros), 64'd0);

    start(35'h0);
    chk("empty_map_win", 64'({fim_jogo, vitoria, tiros}), 64'({1'b1, 1'b1, 6'd0}));

    $display("[TB] %0d tests run, %0d failed", n, nf);
    $finish;
  end
endmodule

// File: doc/disparo_mapa.md
DISPARO_MAPA -- requirements
Module: disparo_mapa

Interface
REQ-001 Parameter: MAX_TIROS, 20, shot limit per game; legal range 1..35.
REQ-002 clk_div  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ativo  input  1  game enable level; 1 = game running, 0 = return to idle and clear.
REQ-005 botao  input  1  fire button, active-high level; the block detects the rising edge internally.
REQ-006 linha  input  3  target row, 0..6.
REQ-007 coluna  input  3  target column, 0..4 (a..e).
REQ-008 pos  input  35  saved position matrix, bit index = linha*5 + coluna; held stable by its source while ativo=1.
REQ-009 mapa_tiros  output  35  cells already fired at.
REQ-010 mapa_acertos  output  35  cells fired at that hold a ship.
REQ-011 tiros  output  6  count of valid, non-repeated shots.
REQ-012 acertos  output  6  count of hits.
REQ-013 acerto, agua, repetido, invalido  output  1 each  one-cycle result pulses.
REQ-014 fim_jogo  output  1  game over.
REQ-015 vitoria  output  1  game won; meaningful only while fim_jogo=1.

Function
REQ-016 The state machine SHALL have exactly four states: ESPERA, JOGANDO, VERIFICA, FIM.
REQ-017 Fire event SHALL be defined as botao=1 on the current edge and botao=0 on the previous edge; the edge register updates every cycle in every state.
REQ-018 ESPERA with ativo=1 SHALL latch total = popcount(pos) in a 6-bit register and move to JOGANDO, or to FIM with vitoria=1 when total=0.
REQ-019 JOGANDO with a fire event SHALL latch linha and coluna and move to VERIFICA on the next edge.
REQ-020 VERIFICA SHALL last exactly one cycle; all result pulses, matrix updates and counter updates become visible at the edge that leaves VERIFICA.
REQ-021 The resulting latency SHALL be exactly 2 cycles from the edge that samples botao=1 to the visible result pulse.
REQ-022 A latched linha>6 or coluna>4 SHALL pulse invalido only; matrices and counters stay unchanged.
REQ-023 A valid cell with mapa_tiros already set SHALL pulse repetido only; counters stay unchanged.
REQ-024 Any other valid cell SHALL set its mapa_tiros bit and increment tiros.
REQ-025 If the pos bit of that cell is 1, the block SHALL also set its mapa_acertos bit, increment acertos and pulse acerto; otherwise it pulses agua.
REQ-026 Exit from VERIFICA SHALL use post-update counts:
- acertos==total -> FIM with vitoria=1;
- else tiros==MAX_TIROS -> FIM with vitoria=0;
- else -> JOGANDO.
REQ-027 A win SHALL take priority when the last allowed shot is also the final hit.
REQ-028 FIM SHALL hold fim_jogo=1, vitoria, both matrices and both counters, and SHALL ignore fire events.
REQ-029 Fire events arriving during VERIFICA SHALL be dropped, not queued.
REQ-030 A held botao SHALL produce exactly one shot.
REQ-031 ativo=0 in JOGANDO, VERIFICA or FIM SHALL move to ESPERA on the next edge, clearing matrices, counters, fim_jogo, vitoria and total; this takes precedence over the VERIFICA result.
REQ-032 At most one result pulse SHALL be high in any cycle; all pulses are 0 outside the cycle after VERIFICA.
REQ-033 Counters SHALL never wrap: tiros ≤ MAX_TIROS and acertos ≤ total by construction.

Reset
REQ-034 reset=1 SHALL have priority over every other input in every state, including mid-VERIFICA.
REQ-035 On reset the block SHALL force: state ESPERA; mapa_tiros=0, mapa_acertos=0, tiros=0, acertos=0, total=0; all pulses=0; fim_jogo=0, vitoria=0; the edge register = 0.
REQ-036 After reset is released, a botao already high SHALL count as a fire event on the first edge only if the block is in JOGANDO.

Verification
REQ-037 Single hit: pos bits 0,1,2 set; ativo=1; fire linha=0, coluna=0 -> acerto pulses 2 cycles after the edge; mapa_acertos[0]=1, mapa_tiros[0]=1, acertos=1, tiros=1.
REQ-038 Miss then repeat: same pos; fire (0,3) -> agua, tiros=1, acertos=0; fire (0,3) again -> repetido, counters unchanged; held botao for 10 cycles -> one result pulse only.
REQ-039 Invalid coordinate: fire coluna=5, then linha=7 -> invalido on each; tiros=0, both matrices=0.
REQ-040 Win and loss:
- pos bits 0 and 34 set, fire (0,0) then (6,4) -> fim_jogo=1, vitoria=1, acertos=2;
- MAX_TIROS=3, three distinct misses -> fim_jogo=1, vitoria=0, tiros=3, and a fourth fire produces no pulse.
REQ-041 Abort and empty map:
- reset asserted in the VERIFICA cycle -> no pulse and all outputs 0 next cycle;
- ativo dropped in FIM -> full clear in ESPERA;
- pos=0 with ativo=1 -> FIM with vitoria=1.
